// File: rtl/data_selector_4x8.sv
// Four-cell scratch register store. Stores data_i into cell[adr_i] when read_sig_i is high,
// and registers cell[adr_i] onto data_o when write_sig_i is high.
module data_selector_4x8 #(
    parameter int DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [1:0]        adr_i,
    input  logic              read_sig_i,
    input  logic              write_sig_i,
    output logic [DATA_W-1:0] data_o
);

    logic [DATA_W-1:0] cell_1;
    logic [DATA_W-1:0] cell_2;
    logic [DATA_W-1:0] cell_3;
    logic [DATA_W-1:0] cell_4;

    logic [3:0]        store_en;
    logic [DATA_W-1:0] sel_data;

    // One-hot store decode; an unknown enable resolves to no store.
    always_comb begin
        store_en = 4'b0000;
        if (read_sig_i == 1'b1) begin
            case (adr_i)
                2'd0:    store_en = 4'b0001;
                2'd1:    store_en = 4'b0010;
                2'd2:    store_en = 4'b0100;
                2'd3:    store_en = 4'b1000;
                default: store_en = 4'b0000;
            endcase
        end
    end

    // Read mux sees the pre-edge cell contents, so a same-edge store is never bypassed.
    always_comb begin
        sel_data = '0;
        case (adr_i)
            2'd0:    sel_data = cell_1;
            2'd1:    sel_data = cell_2;
            2'd2:    sel_data = cell_3;
            2'd3:    sel_data = cell_4;
            default: sel_data = '0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cell_1 <= '0;
        end else if (store_en[0]) begin
            cell_1 <= data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cell_2 <= '0;
        end else if (store_en[1]) begin
            cell_2 <= data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cell_3 <= '0;
        end else if (store_en[2]) begin
            cell_3 <= data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cell_4 <= '0;
        end else if (store_en[3]) begin
            cell_4 <= data_i;
        end
    end

    // data_o holds its last value whenever write_sig_i is low.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_o <= '0;
        end else if (write_sig_i == 1'b1) begin
            data_o <= sel_data;
        end
    end

endmodule

// File: tb/tb_data_selector_4x8.sv
// Directed bench for data_selector_4x8: a behavioural model of the four cells predicts data_o,
// which is queued at drive time and compared one edge later; cells are also checked hierarchically.
module tb_data_selector_4x8;

    localparam int DATA_W = 8;

    logic              clk_i;
    logic              rst_i;
    logic [DATA_W-1:0] data_i;
    logic [1:0]        adr_i;
    logic              read_sig_i;
    logic              write_sig_i;
    logic [DATA_W-1:0] data_o;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] m_cell[4];
    logic [DATA_W-1:0] m_out;

    data_selector_4x8 #(.DATA_W(DATA_W)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .data_i      (data_i),
        .adr_i       (adr_i),
        .read_sig_i  (read_sig_i),
        .write_sig_i (write_sig_i),
        .data_o      (data_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_cells(input string tag);
        check({tag, " cell_1"}, dut.cell_1, m_cell[0]);
        check({tag, " cell_2"}, dut.cell_2, m_cell[1]);
        check({tag, " cell_3"}, dut.cell_3, m_cell[2]);
        check({tag, " cell_4"}, dut.cell_4, m_cell[3]);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_cell[i] = '0;
        m_out = '0;
    endtask

    // Drives one cycle (called just after a rising edge), predicts data_o, then checks after the edge.
    task automatic step(input string tag, input logic rd, input logic wr,
                        input logic [1:0] adr, input logic [DATA_W-1:0] dat);
        logic [DATA_W-1:0] got;
        read_sig_i  = rd;
        write_sig_i = wr;
        adr_i       = adr;
        data_i      = dat;
        if (wr) m_out = m_cell[adr];
        if (rd) m_cell[adr] = dat;
        exp_q.push_back(m_out);
        @(posedge clk_i);
        #1;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $error("FAIL %s: scoreboard queue empty", tag);
        end else begin
            got = exp_q.pop_front();
            check({tag, " data_o"}, data_o, got);
        end
        check_cells(tag);
    endtask

    initial begin
        rst_i       = 1'b1;
        data_i      = '0;
        adr_i       = '0;
        read_sig_i  = 1'b0;
        write_sig_i = 1'b0;
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        check("reset data_o", data_o, '0);
        check_cells("reset");
        rst_i = 1'b0;

        // Sequential store, data_o stays 0
        step("store0", 1'b1, 1'b0, 2'd0, 8'd64);
        step("store1", 1'b1, 1'b0, 2'd1, 8'd32);
        step("store2", 1'b1, 1'b0, 2'd2, 8'd2);
        step("store3", 1'b1, 1'b0, 2'd3, 8'd1);

        // Output then hold
        step("out1", 1'b0, 1'b1, 2'd1, 8'd0);
        step("out3", 1'b0, 1'b1, 2'd3, 8'd0);
        step("hold", 1'b0, 1'b0, 2'd0, 8'd0);
        step("hold2", 1'b0, 1'b0, 2'd2, 8'd77);

        // Simultaneous enables: old content out, new content stored
        step("simul", 1'b1, 1'b1, 2'd2, 8'd99);
        step("after_simul", 1'b0, 1'b1, 2'd2, 8'd0);

        // Isolation
        step("iso", 1'b1, 1'b0, 2'd0, 8'hAA);
        step("iso_out0", 1'b0, 1'b1, 2'd0, 8'd0);

        // Random mix of stores and outputs
        for (int i = 0; i < 24; i++) begin
            step("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
        end
        step("pre_rst_fill", 1'b1, 1'b1, 2'd3, 8'h5C);
        step("pre_rst_out", 1'b0, 1'b1, 2'd3, 8'd0);

        // Asynchronous reset mid-cycle, checked before any further edge
        #2;
        rst_i = 1'b1;
        #1;
        model_reset();
        check("async rst data_o", data_o, '0);
        check_cells("async rst");
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        step("refill0", 1'b1, 1'b0, 2'd1, 8'h3C);
        step("refill1", 1'b1, 1'b1, 2'd1, 8'h11);

        // Reset held across an edge with a pending store and output
        read_sig_i  = 1'b1;
        write_sig_i = 1'b1;
        adr_i       = 2'd1;
        data_i      = 8'hF0;
        rst_i       = 1'b1;
        model_reset();
        @(posedge clk_i);
        #1;
        check("rst mid-store data_o", data_o, '0);
        check_cells("rst mid-store");
        read_sig_i  = 1'b0;
        write_sig_i = 1'b0;
        rst_i       = 1'b0;

        step("post_rst_out", 1'b0, 1'b1, 2'd1, 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/data_selector_4x8.md
Name:
data_selector_4x8

Overview:
- Small 4-entry x 8-bit register store with a registered read-out port.
- When read_sig_i is high, the block captures (stores) data_i into the cell selected by adr_i.
- When write_sig_i is high, the block drives (outputs) the content of the selected cell on data_o.
- Signal names are from the block's point of view: "read" means take data in, "write" means put data out.
- Used as a simple addressable scratch buffer between a producer and a consumer datapath.

Parameters:
- DATA_W, 8, width of each cell, of data_i and of data_o.
- NUM_CELLS is fixed at 4 and is not a parameter. adr_i is 2 bits.

Ports:
- clk_i  input  1  system clock; all state updates on rising edge.
- rst_i  input  1  asynchronous reset, active-high. Clears all cells and data_o.
- data_i  input  DATA_W  data to store.
- adr_i  input  2  cell select: 0 selects cell_1, 1 selects cell_2, 2 selects cell_3, 3 selects cell_4.
- read_sig_i  input  1  store enable. Active-high, sampled on the rising edge.
- write_sig_i  input  1  output enable. Active-high, sampled on the rising edge.
- data_o  output  DATA_W  registered output data.

Behaviour:
- Internal storage is four registers: cell_1, cell_2, cell_3, cell_4, each DATA_W bits.
- Reset (rst_i high, asynchronous, no clock needed):
  - cell_1..cell_4 go to 0.
  - data_o goes to 0.
  - State holds at 0 while rst_i stays high.
  - On deassertion, normal operation starts at the next rising edge.
  - Reset asserted mid-operation aborts any pending store or output; nothing from that cycle takes effect.
- Store: at a rising edge with read_sig_i=1, cell[adr_i] <= data_i.
  - The stored value is visible internally one cycle later.
  - The other cells are unchanged.
  - Back-to-back stores on consecutive cycles are allowed, one cell per cycle.
- Output: at a rising edge with write_sig_i=1, data_o <= cell[adr_i].
  - Latency is 1 clock from the sampled adr_i to data_o.
  - With write_sig_i held high, data_o follows adr_i each cycle, 1 cycle late.
- Hold: with write_sig_i=0, data_o keeps its last value. It is not cleared.
- Simultaneous read_sig_i=1 and write_sig_i=1 in the same cycle:
  - Both actions happen at the same edge.
  - data_o receives the OLD content of cell[adr_i], i.e. the value before this edge's store. There is no bypass or write-through.
  - The store completes normally; the new value appears on data_o at the next output cycle.
- Both enables low: no state change at all.
- Addressing: all 4 codes are valid; there is no out-of-range case and no wrap logic.
- X or unknown on an enable input is not a supported condition; the implementation may treat it as 0.
- No combinational path from any input to data_o.
- The cell registers must be observable hierarchically as cell_1..cell_4 for verification.

Test Plan:
- Reset check: assert rst_i asynchronously mid-cycle with prior nonzero contents -> data_o and all cells become 0 immediately, without a clock edge.
- Sequential store: read_sig_i=1 for 4 cycles with (adr,data) = (0,64), (1,32), (2,2), (3,1) -> cell_1=64, cell_2=32, cell_3=2, cell_4=1; data_o stays 0 because write_sig_i=0.
- Output with hold:
  - Raise write_sig_i with adr_i=1 -> data_o=32 one clock after the sampling edge.
  - Then drive adr_i=3 -> data_o=1 on the next edge.
  - Drop write_sig_i and change adr_i to 0 -> data_o holds 1.
- Simultaneous enables: cell_3=2, then one cycle with read_sig_i=1, write_sig_i=1, adr_i=2, data_i=99 -> data_o=2 and cell_3=99. The following output cycle at adr 2 -> data_o=99.
- Isolation: store 0xAA to adr 0 only -> cells 2..4 unchanged.
- Reset mid-store: pulse rst_i during a cycle with read_sig_i=1 -> no store takes effect and all contents are 0 afterwards.
